// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column at a time, 2-flop row sync,
// whole-frame debounce, one-cycle key_valid pulse per accepted press.
module keypad_scanner #(
  parameter int CLK_DIV  = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0]    DB       = 4'(DEBOUNCE);

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;
  typedef enum logic {IDLE, PRESSED} state_t;

  logic [3:0]    sync1, sync2;
  logic [DW-1:0] div;
  logic [1:0]    col;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_key;
  cls_t          prev_cls;
  logic [3:0]    prev_key;
  logic [3:0]    stab;
  state_t        state;

  logic       tick;
  logic [2:0] col_cnt;
  logic [1:0] row_idx;
  logic [1:0] base_cnt;
  logic [2:0] sum;
  logic [1:0] frame_cnt;
  logic [3:0] frame_key;
  cls_t       cur_cls;
  logic       same;
  logic [3:0] stab_nxt;
  logic       accept;

  // Key count per frame saturates at 2: only NONE/SINGLE/MULTI matter.
  always_comb begin
    tick    = (div == DIV_LAST);
    col_cnt = '0;
    row_idx = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!sync2[r]) begin
        col_cnt = col_cnt + 3'd1;
        row_idx = 2'(r);
      end
    end
    base_cnt  = (col == 2'd0) ? 2'd0 : acc_cnt;
    sum       = {1'b0, base_cnt} + col_cnt;
    frame_cnt = (sum > 3'd2) ? 2'd2 : sum[1:0];
    frame_key = (base_cnt == 2'd0 && col_cnt != 3'd0) ? {row_idx, col} : acc_key;
    case (frame_cnt)
      2'd0:    cur_cls = CLS_NONE;
      2'd1:    cur_cls = CLS_SINGLE;
      default: cur_cls = CLS_MULTI;
    endcase
    same     = (cur_cls == prev_cls) && (cur_cls != CLS_SINGLE || frame_key == prev_key);
    stab_nxt = !same ? 4'd1 : ((stab >= DB) ? stab : stab + 4'd1);
    // Fires only on the frame where the count first reaches DEBOUNCE.
    accept   = (stab_nxt == DB) && !(same && stab == DB);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1     <= '1;
      sync2     <= '1;
      div       <= '0;
      col       <= '0;
      col_n     <= 4'b1110;
      acc_cnt   <= '0;
      acc_key   <= '0;
      prev_cls  <= CLS_NONE;
      prev_key  <= '0;
      stab      <= '0;
      state     <= IDLE;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      sync1     <= row_n;
      sync2     <= sync1;
      key_valid <= 1'b0;
      if (tick) begin
        div     <= '0;
        col     <= col + 2'd1;
        col_n   <= ~(4'b0001 << (col + 2'd1));
        acc_cnt <= frame_cnt;
        acc_key <= frame_key;
        if (col == 2'd3) begin
          prev_cls <= cur_cls;
          prev_key <= frame_key;
          stab     <= stab_nxt;
          case (state)
            IDLE: begin
              if (accept && cur_cls == CLS_SINGLE) begin
                key_code  <= frame_key;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= PRESSED;
              end
            end
            PRESSED: begin
              if (accept && cur_cls == CLS_NONE) begin
                key_held <= 1'b0;
                state    <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with CLK_DIV=8, DEBOUNCE=3 and a
// behavioural keypad that pulls a row low while its column is driven.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] closed = '0;

  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   dbl = 0;
  logic kv_d = 1'b0;

  keypad_scanner #(.CLK_DIV(8), .DEBOUNCE(3)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (closed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulses++;
      if (kv_d) dbl++;
    end
    kv_d = key_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (key_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_release(input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (!key_held) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_frame_start();
    int n = 0;
    while (col_n != 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (col_n != 4'b1110 && n < 200) begin @(negedge clk); n++; end
    check("frame_sync", int'(n < 200), 1);
  endtask

  initial begin
    int lat;
    int p0;
    logic [3:0] exp_col;

    repeat (3) @(negedge clk);
    check("rst_col", col_n, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);

    // Scan order after reset release with no keys.
    rstn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      exp_col = ~(4'b0001 << ((i / 8) % 4));
      check("scan_col", col_n, exp_col);
      if (key_valid || key_held || key_code != 4'd0) check("scan_quiet", 1, 0);
      @(negedge clk);
    end

    // Single press (2,1) -> code 9, then release.
    p0 = pulses;
    closed[9] = 1'b1;
    wait_valid(200, lat);
    check("press_seen", int'(lat > 0), 1);
    check("press_lat", int'(lat <= 131), 1);
    check("press_code", key_code, 9);
    check("press_held", key_held, 1);
    @(negedge clk);
    check("press_width", key_valid, 0);
    repeat (150) @(negedge clk);
    check("press_once", pulses - p0, 1);
    closed = '0;
    repeat (64) @(negedge clk);
    check("release_early", key_held, 1);
    wait_release(200, lat);
    check("release_seen", int'(lat > 0), 1);
    check("release_lat", int'(lat + 64 <= 131), 1);
    check("release_nopulse", pulses - p0, 1);
    check("release_code", key_code, 9);

    // Bounce on (0,3): 2 closed frames, 1 open, then steady.
    p0 = pulses;
    wait_frame_start();
    closed[3] = 1'b1;
    repeat (64) @(negedge clk);
    closed = '0;
    repeat (32) @(negedge clk);
    closed[3] = 1'b1;
    repeat (64) @(negedge clk);
    check("bounce_early", pulses - p0, 0);
    wait_valid(40, lat);
    check("bounce_seen", int'(lat > 0), 1);
    check("bounce_code", key_code, 3);
    closed = '0;
    wait_release(200, lat);
    check("bounce_release", int'(lat > 0), 1);

    // Ghosting: (1,0)+(1,2) rejected, then (1,0) alone accepted.
    p0 = pulses;
    closed[4] = 1'b1;
    closed[6] = 1'b1;
    repeat (200) @(negedge clk);
    check("ghost_nopulse", pulses - p0, 0);
    check("ghost_held", key_held, 0);
    closed[6] = 1'b0;
    wait_valid(200, lat);
    check("ghost_seen", int'(lat > 0), 1);
    check("ghost_code", key_code, 4);
    closed = '0;
    wait_release(200, lat);
    check("ghost_release", int'(lat > 0), 1);

    // Roll-over: (3,3) then (0,0) without full release.
    p0 = pulses;
    closed[15] = 1'b1;
    wait_valid(200, lat);
    check("roll_seen", int'(lat > 0), 1);
    check("roll_code", key_code, 15);
    closed[0] = 1'b1;
    repeat (150) @(negedge clk);
    closed[15] = 1'b0;
    repeat (150) @(negedge clk);
    check("roll_nopulse", pulses - p0, 1);
    check("roll_keep", key_code, 15);
    check("roll_held", key_held, 1);
    closed = '0;
    wait_release(200, lat);
    check("roll_release", int'(lat > 0), 1);
    closed[0] = 1'b1;
    wait_valid(200, lat);
    check("roll_new_seen", int'(lat > 0), 1);
    check("roll_new_code", key_code, 0);
    closed = '0;
    wait_release(200, lat);
    check("roll_new_release", int'(lat > 0), 1);

    // Reset while (2,2) is held.
    closed[10] = 1'b1;
    wait_valid(200, lat);
    check("mid_seen", int'(lat > 0), 1);
    check("mid_code", key_code, 10);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_held", key_held, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_col", col_n, 4'b1110);
    check("mid_rst_valid", key_valid, 0);
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    p0 = pulses;
    wait_valid(200, lat);
    check("mid_again_seen", int'(lat > 0), 1);
    check("mid_again_lat", int'(lat <= 131), 1);
    check("mid_again_code", key_code, 10);
    check("mid_again_held", key_held, 1);
    repeat (150) @(negedge clk);
    check("mid_again_once", pulses - p0, 1);
    closed = '0;

    check("pulse_width_all", dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad scanner for the board's 4x4 key matrix, the input-side counterpart to the seven-segment display controller. It drives one keypad column low at a time, samples the active-low row lines, and debounces across whole scan frames. It reports each accepted key press as a one-cycle `key_valid` pulse with a 4-bit key code, so the display and control logic can consume key events directly.

## Interface

- `CLK_DIV`, default 1000: clock cycles each column is driven per scan step; minimum 4.
- `DEBOUNCE`, default 4: consecutive identical scan frames required to accept a press or a release; range 1..15.

- `clk`  input  1  system clock; all logic on the rising edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `row_n`  input  4  keypad rows, active-low with external pull-ups, asynchronous to `clk`.
- `col_n`  output  4  column drive, active-low, one-hot-low.
- `key_valid`  output  1  one-cycle pulse when a press is accepted.
- `key_code`  output  4  code of the last accepted key, `row*4 + col`; holds its value until the next accepted press.
- `key_held`  output  1  high from acceptance of a press until acceptance of the release.

## Operation

- `row_n` passes through a 2-flop synchronizer before any use.
- Divider counts 0..CLK_DIV-1 and wraps. Column index 0..3 advances on each wrap, 3 wraps to 0.
- `col_n` is `~(1 << col)`, registered.
- The synchronized rows are sampled on the divider's terminal cycle, before the column changes. A sampled row bit `r` low in column `c` marks key `r*4+c` pressed.
- One frame is columns 0..3, i.e. 4*CLK_DIV cycles. At the column-3 sample, the frame is classified:
  - NONE: 0 keys pressed.
  - SINGLE(k): exactly 1 key pressed.
  - MULTI: 2 or more keys pressed.
- Stability counter:
  - Classification equal to the previous frame (same class and, for SINGLE, same k): increment, saturating at DEBOUNCE.
  - Otherwise: set to 1.
- FSM:
  - IDLE: when the counter reaches DEBOUNCE with SINGLE(k), latch `key_code`=k, pulse `key_valid`, set `key_held`, go to PRESSED. NONE and MULTI never trigger.
  - PRESSED: when the counter reaches DEBOUNCE with NONE, clear `key_held` and go to IDLE. SINGLE of any key and MULTI keep PRESSED with no new event. A new press therefore requires a debounced release first.
- Acceptance fires once per transition. Saturation prevents re-triggering while the counter stays at DEBOUNCE.
- Reset values (asynchronous assert):
  - `col_n`=4'b1110, `key_valid`=0, `key_code`=0, `key_held`=0.
  - Divider, column, stability counter and previous classification cleared; previous classification = NONE.
  - Synchronizer flops = 4'b1111.
  - FSM = IDLE.
- Reset released while a key is still held: the key is treated as a new press and accepted after DEBOUNCE frames.

## Timing

- Column slot: CLK_DIV cycles. Rows settle for CLK_DIV-1 cycles, plus 2 synchronizer cycles, before sampling.
- `key_valid` and `key_held` rise, and `key_code` updates, in the cycle after the column-3 sample of the DEBOUNCE-th consecutive matching frame.
- `key_valid` is high exactly 1 cycle.
- Press latency from a stable closure: at most (DEBOUNCE+1)*4*CLK_DIV + 3 cycles. Release latency is the same bound.
- No back-pressure: events are not queued, and the consumer must sample the `key_valid` pulse.

## Test plan

All scenarios use CLK_DIV=8, DEBOUNCE=3. The bench models the keypad by driving `row_n[r]`=0 while `col_n[c]`=0 for each closed key (r,c).

- Reset/scan: hold `rstn` low, then release, with no keys → `col_n`=1110, 1101, 1011, 0111, repeating, each for 8 cycles; `key_valid`, `key_held` and `key_code` stay 0.
- Single press/release: close (2,1) and hold → exactly one `key_valid` pulse, `key_code`=9, `key_held`=1, at most 131 cycles after closure. Open it → `key_held`=0 after 3 NONE frames, no pulse.
- Bounce: close (0,3) for 2 frames, open for 1 frame, then close steadily → no pulse until 3 consecutive closed frames, then one pulse with `key_code`=3.
- Ghosting: close (1,0) and (1,2) together → no pulse, `key_held`=0. Open (1,2) → pulse with `key_code`=4 after 3 frames.
- Roll-over: hold (3,3) (code 15, accepted), then also close and later switch to (0,0) without releasing all keys → no new pulse, `key_code` stays 15. Release all for 3 frames, then press (0,0) → pulse with `key_code`=0.
- Reset mid-press: with (2,2) accepted, assert `rstn` → `key_held`=0, `key_code`=0 and `col_n`=1110 immediately. Release `rstn` with the key still closed → one new pulse with `key_code`=10 after 3 frames.
